// File: rtl/mixer_pkg.sv
// mixer_pkg: shared sweep state type and bounded gain step arithmetic for mixer_gain_ramper
package mixer_pkg;
   localparam int GAIN_MAX_W = 32;
   typedef enum logic {RAMP_IDLE_E, RAMP_SWEEP_E} ramp_state_t;
   function automatic logic [GAIN_MAX_W-1:0] gain_step(
      input logic [GAIN_MAX_W-1:0] cur,
      input logic [GAIN_MAX_W-1:0] tgt,
      input logic [GAIN_MAX_W-1:0] step
   );
      logic [GAIN_MAX_W:0] diff;
      diff = tgt > cur ? {1'b0, tgt} - {1'b0, cur} : {1'b0, cur} - {1'b0, tgt};
      return (step == '0 || diff <= {1'b0, step}) ? tgt : tgt > cur ? cur + step : cur - step;
   endfunction
endpackage

// File: rtl/mixer_gain_ramper.sv
// mixer_gain_ramper: per-strobe sweep moving each applied gain toward its target by at most cr_mix_ramp_step
// MIXER_GAIN_RAMP_MUTE_EN enables cr_mix_mute and sr_mix_muted
module mixer_gain_ramper
   import mixer_pkg::*;
#(
   parameter int GAIN_WIDTH_P     = 16,
   parameter int NR_OF_CHANNELS_P = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fs_strobe,
   input  logic [GAIN_WIDTH_P-1:0] cr_mix_channel_gain [NR_OF_CHANNELS_P],
   input  logic [GAIN_WIDTH_P-1:0] cr_mix_output_gain,
   input  logic [GAIN_WIDTH_P-1:0] cr_mix_ramp_step,
   input  logic                    cr_mix_mute,
   input  logic                    cmd_mix_clear_ramp_overrun,
   output logic [GAIN_WIDTH_P-1:0] mix_channel_gain [NR_OF_CHANNELS_P],
   output logic [GAIN_WIDTH_P-1:0] mix_output_gain,
   output logic                    sr_mix_ramp_settled,
   output logic                    sr_mix_ramp_overrun,
   output logic                    sr_mix_muted
);
   localparam int N  = NR_OF_CHANNELS_P;
   localparam int IW = $clog2(N + 1);
   ramp_state_t state;
   logic [IW-1:0] idx;
   logic [GAIN_WIDTH_P-1:0] cur [N+1];
   logic [GAIN_WIDTH_P-1:0] tgt [N+1];
   logic [GAIN_WIDTH_P-1:0] nxt;
   logic mute_on, all_eq, all_zero, last;
`ifdef MIXER_GAIN_RAMP_MUTE_EN
   assign mute_on = cr_mix_mute;
`else
   logic mute_unused;
   assign mute_unused = cr_mix_mute;
   assign mute_on = 1'b0;
`endif
   always_comb begin
      for (int i = 0; i < N; i++) tgt[i] = mute_on ? '0 : cr_mix_channel_gain[i];
      tgt[N] = mute_on ? '0 : cr_mix_output_gain;
      all_eq = 1'b1;
      all_zero = 1'b1;
      for (int i = 0; i <= N; i++) begin
         all_eq = all_eq & (cur[i] == tgt[i]);
         all_zero = all_zero & (cur[i] == '0);
      end
   end
   always_comb begin
      for (int i = 0; i < N; i++) mix_channel_gain[i] = cur[i];
   end
   assign mix_output_gain = cur[N];
   assign last = idx == IW'(N);
   // targets are sampled live, so mid-sweep register writes reach only unprocessed indices
   assign nxt = GAIN_WIDTH_P'(gain_step(GAIN_MAX_W'(cur[idx]), GAIN_MAX_W'(tgt[idx]), GAIN_MAX_W'(cr_mix_ramp_step)));
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RAMP_IDLE_E;
         idx <= '0;
         for (int i = 0; i <= N; i++) cur[i] <= '0;
         sr_mix_ramp_settled <= 1'b0;
         sr_mix_ramp_overrun <= 1'b0;
         sr_mix_muted <= 1'b0;
      end else begin
         if (state == RAMP_IDLE_E) begin
            if (fs_strobe) begin
               state <= RAMP_SWEEP_E;
               idx <= '0;
            end
         end else begin
            cur[idx] <= nxt;
            idx <= last ? '0 : idx + 1'b1;
            state <= last ? RAMP_IDLE_E : RAMP_SWEEP_E;
         end
         sr_mix_ramp_overrun <= (fs_strobe && state == RAMP_SWEEP_E) || (sr_mix_ramp_overrun && !cmd_mix_clear_ramp_overrun);
         sr_mix_ramp_settled <= all_eq;
         sr_mix_muted <= mute_on && all_zero;
      end
   end
endmodule

// File: tb/tb_mixer_gain_ramper.sv
// tb_mixer_gain_ramper: scoreboard bench comparing gains and status against a cycle-indexed reference model
module tb_mixer_gain_ramper;
   localparam int N = 4;
   localparam int W = 16;
   typedef struct packed {
      int cyc;
      logic [N:0][W-1:0] g;
      logic flags;
      logic settled;
      logic muted;
   } exp_t;
   typedef struct packed {
      int cyc;
      logic v;
   } ov_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fs_strobe = 1'b0;
   logic cr_mix_mute = 1'b0;
   logic cmd_clr = 1'b0;
   logic [W-1:0] cr_ch [N];
   logic [W-1:0] cr_out = '0;
   logic [W-1:0] cr_step = '0;
   logic [W-1:0] mix_ch [N];
   logic [W-1:0] mix_out;
   logic settled, overrun, muted;
   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   bit done = 1'b0;
   exp_t sb[$];
   ov_t oq[$];
   int mg [N+1];
   bit m_over = 1'b0;
   int busy_end = -1;

   mixer_gain_ramper #(.GAIN_WIDTH_P(W), .NR_OF_CHANNELS_P(N)) dut (
      .clk(clk), .rst(rst), .fs_strobe(fs_strobe),
      .cr_mix_channel_gain(cr_ch), .cr_mix_output_gain(cr_out), .cr_mix_ramp_step(cr_step),
      .cr_mix_mute(cr_mix_mute), .cmd_mix_clear_ramp_overrun(cmd_clr),
      .mix_channel_gain(mix_ch), .mix_output_gain(mix_out),
      .sr_mix_ramp_settled(settled), .sr_mix_ramp_overrun(overrun), .sr_mix_muted(muted)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit mute_on();
`ifdef MIXER_GAIN_RAMP_MUTE_EN
      return cr_mix_mute;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int eff(int k);
      if (mute_on()) return 0;
      return k == N ? int'(cr_out) : int'(cr_ch[k]);
   endfunction

   // one gain moves toward its target by at most s; s == 0 jumps
   function automatic int step_model(int c, int t, int s);
      int d = t > c ? t - c : c - t;
      if (s == 0 || d <= s) return t;
      return t > c ? c + s : c - s;
   endfunction

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_all(logic [W-1:0] v);
      for (int k = 0; k < N; k++) cr_ch[k] = v;
      cr_out = v;
   endtask

   task automatic push_ov(int c, bit v);
      ov_t o;
      o.cyc = c;
      o.v = v;
      oq.push_back(o);
   endtask

   task automatic strobe(bit clr = 1'b0);
      int nv [N+1];
      int c = cyc;
      bit busy = (c <= busy_end);
      fs_strobe = 1'b1;
      cmd_clr = clr;
      m_over = busy | (m_over & ~clr);
      if (!busy) begin
         busy_end = c + N + 1;
         for (int k = 0; k <= N; k++) nv[k] = step_model(mg[k], eff(k), int'(cr_step));
         for (int j = 0; j <= N + 2; j++) begin
            exp_t e;
            bit se = 1'b1;
            bit mz = 1'b1;
            e.cyc = c + 1 + j;
            for (int k = 0; k <= N; k++) begin
               int v = k < j ? nv[k] : mg[k];
               int vp = k < j - 1 ? nv[k] : mg[k];
               e.g[k] = W'(v);
               se &= (vp == eff(k));
               mz &= (vp == 0);
            end
            e.flags = j >= 1;
            e.settled = se;
            e.muted = mute_on() && mz;
            sb.push_back(e);
         end
         mg = nv;
      end
      push_ov(c + 1, m_over);
      tick();
      fs_strobe = 1'b0;
      cmd_clr = 1'b0;
   endtask

   task automatic clear_only();
      cmd_clr = 1'b1;
      m_over = 1'b0;
      push_ov(cyc + 1, 1'b0);
      tick();
      cmd_clr = 1'b0;
   endtask

   task automatic do_reset();
      int c = cyc;
      exp_t e;
      rst = 1'b1;
      while (sb.size() > 0 && sb[$].cyc > c) void'(sb.pop_back());
      while (oq.size() > 0 && oq[$].cyc > c) void'(oq.pop_back());
      for (int k = 0; k <= N; k++) mg[k] = 0;
      m_over = 1'b0;
      busy_end = -1;
      e.cyc = c + 1;
      e.g = '0;
      e.flags = 1'b1;
      e.settled = 1'b0;
      e.muted = 1'b0;
      sb.push_back(e);
      push_ov(c + 1, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   exp_t ee;
   ov_t oo;
   logic [N:0][W-1:0] act;
   always @(negedge clk) begin
      for (int k = 0; k < N; k++) act[k] = mix_ch[k];
      act[N] = mix_out;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         ee = sb.pop_front();
         vectors++;
         if (ee.cyc != cyc || act != ee.g) begin
            miscompares++;
            $display("FAIL gains cyc=%0d due=%0d actual=%h expected=%h", cyc, ee.cyc, act, ee.g);
         end
         if (ee.flags) begin
            vectors++;
            if ({settled, muted} != {ee.settled, ee.muted}) begin
               miscompares++;
               $display("FAIL flags cyc=%0d actual settled/muted=%b%b expected=%b%b", cyc, settled, muted, ee.settled, ee.muted);
            end
         end
      end
      while (oq.size() > 0 && oq[0].cyc <= cyc) begin
         oo = oq.pop_front();
         vectors++;
         if (oo.cyc != cyc || overrun != oo.v) begin
            miscompares++;
            $display("FAIL overrun cyc=%0d due=%0d actual=%b expected=%b", cyc, oo.cyc, overrun, oo.v);
         end
      end
      if (done) begin
         vectors++;
         if (sb.size() != 0 || oq.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d expected=0", sb.size() + oq.size());
         end
         $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
         $finish;
      end
      if (cyc > 50000) begin
         $display("FAIL timeout cyc=%0d limit=50000", cyc);
         $fatal(1);
      end
   end

   initial begin
      int g1;
      set_all('0);
      tick();
      do_reset();
      cr_step = 16'h0400;
      set_all(16'h1000);
      repeat (4) begin strobe(); tick(99); end
      do_reset();
      set_all(16'h0FFF);
      repeat (4) begin strobe(); tick(20); end
      set_all(16'h0000);
      repeat (4) begin strobe(); tick(20); end
      cr_step = '0;
      set_all(16'hABCD);
      strobe();
      tick(20);
      strobe();
      tick(2);
      strobe();
      tick(N + 3);
      strobe();
      tick(1);
      strobe(1'b1);
      tick(N + 3);
      clear_only();
      tick(3);
      set_all(16'h1000);
      strobe();
      tick(10);
      cr_step = 16'h0800;
      cr_mix_mute = 1'b1;
      repeat (2) begin strobe(); tick(10); end
      cr_mix_mute = 1'b0;
      repeat (2) begin strobe(); tick(10); end
      strobe();
      tick(2);
      do_reset();
      tick(5);
      repeat (2) begin strobe(); tick(10); end
      for (int it = 0; it < 60; it++) begin
         for (int k = 0; k < N; k++) cr_ch[k] = W'($urandom);
         cr_out = W'($urandom);
         cr_step = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 16'h3000));
         cr_mix_mute = ($urandom_range(0, 4) == 0);
         strobe($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) begin
            g1 = $urandom_range(1, N);
            tick(g1);
            strobe($urandom_range(0, 1) == 0);
            tick(N + 2 - g1);
         end else begin
            tick($urandom_range(N + 2, N + 8));
         end
         if ($urandom_range(0, 4) == 0) clear_only();
      end
      tick(N + 5);
      done = 1'b1;
      tick(5);
   end
endmodule
